key_debounce: RTL



---
 rtl/key_debounce.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner.
// Each channel synchronises its raw pin, debounces it with a counter,
// times the hold duration and emits single-cycle press/release/short/long
// events plus a toggle flag that flips on every short press.
// Channels are fully independent; all outputs come straight from flops.
module key_debounce #(
    parameter int CLK_FREQ    = 27_000_000,
    parameter int KEY_NUM     = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 500,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_short,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_toggle
);

    localparam int CYC_MS   = CLK_FREQ / 1000;
    localparam int DEB_CNT  = CYC_MS * DEBOUNCE_MS;
    localparam int LONG_CNT = CYC_MS * LONG_MS;
    localparam int DW       = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int HW       = $clog2(LONG_CNT + 1);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CNT - 1);

    // XOR mask that turns the pin into "1 = pressed" regardless of board wiring
    localparam logic [KEY_NUM-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}}
                                                                : {KEY_NUM{1'b0}};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    logic [KEY_NUM-1:0] sync1_d, sync1_q;
    logic [KEY_NUM-1:0] sync2_d, sync2_q;

    // Polarity-normalise the raw pins and feed the two-flop synchroniser
    always_comb begin
        sync1_d = key ^ POL_MASK;
        sync2_d = sync1_q;
    end

    // Synchroniser flops; the first stage may go metastable, only the second is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {KEY_NUM{1'b0}};
            sync2_q <= {KEY_NUM{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < KEY_NUM; g++) begin : g_chan
            logic [DW-1:0] dcnt_d, dcnt_q;
            logic [HW-1:0] hcnt_d, hcnt_q;
            logic [1:0]    state_d, state_q;
            logic          level_d, level_q;
            logic          press_d, press_q;
            logic          release_d, release_q;
            logic          short_d, short_q;
            logic          long_d, long_q;
            logic          long_done_d, long_done_q;
            logic          toggle_d, toggle_q;
            logic          hold_run_s;

            // Debouncer: the synchronised level must differ for DEB_CNT
            // consecutive cycles before the debounced level follows it
            always_comb begin
                level_d   = level_q;
                dcnt_d    = dcnt_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                if (sync2_q[g] != level_q) begin
                    if (dcnt_q == DEB_MAX) begin
                        level_d   = sync2_q[g];
                        dcnt_d    = {DW{1'b0}};
                        press_d   = sync2_q[g];
                        release_d = ~sync2_q[g];
                    end else begin
                        dcnt_d = dcnt_q + DW'(1'b1);
                    end
                end else begin
                    dcnt_d = {DW{1'b0}};
                end
            end

            // Hold timer, long/short classification and the press state machine
            always_comb begin
                hold_run_s  = (state_q != ST_IDLE) && !release_d;
                hcnt_d      = hcnt_q;
                long_d      = 1'b0;
                long_done_d = long_done_q;
                state_d     = state_q;

                if (press_d) begin
                    hcnt_d = {HW{1'b0}};
                end else if (hold_run_s && (hcnt_q != HOLD_MAX)) begin
                    hcnt_d = hcnt_q + HW'(1'b1);
                    long_d = (hcnt_q == HOLD_PRE);
                end else begin
                    hcnt_d = hcnt_q;
                end

                if (press_d) begin
                    long_done_d = 1'b0;
                end else if (long_d) begin
                    long_done_d = 1'b1;
                end else begin
                    long_done_d = long_done_q;
                end

                // A release only counts as short if the long event never fired
                short_d  = release_d & ~long_done_q;
                toggle_d = toggle_q ^ short_d;

                case (state_q)
                    ST_IDLE: begin
                        if (press_d) begin
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        if (release_d) begin
                            state_d = ST_IDLE;
                        end else if (long_d) begin
                            state_d = ST_LONG;
                        end else begin
                            state_d = ST_PRESSED;
                        end
                    end
                    ST_LONG: begin
                        if (release_d) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LONG;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // Per-channel state and registered event outputs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dcnt_q      <= {DW{1'b0}};
                    hcnt_q      <= {HW{1'b0}};
                    state_q     <= ST_IDLE;
                    level_q     <= 1'b0;
                    press_q     <= 1'b0;
                    release_q   <= 1'b0;
                    short_q     <= 1'b0;
                    long_q      <= 1'b0;
                    long_done_q <= 1'b0;
                    toggle_q    <= 1'b0;
                end else begin
                    dcnt_q      <= dcnt_d;
                    hcnt_q      <= hcnt_d;
                    state_q     <= state_d;
                    level_q     <= level_d;
                    press_q     <= press_d;
                    release_q   <= release_d;
                    short_q     <= short_d;
                    long_q      <= long_d;
                    long_done_q <= long_done_d;
                    toggle_q    <= toggle_d;
                end
            end

            assign key_level[g]   = level_q;
            assign key_press[g]   = press_q;
            assign key_release[g] = release_q;
            assign key_short[g]   = short_q;
            assign key_long[g]    = long_q;
            assign key_toggle[g]  = toggle_q;
        end
    endgenerate

endmodule
